// File: rtl/key_arbiter_pkg.sv
// Shared types and defaults for the key request arbiter.
package key_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  // Index width for a path number; never zero so single-path builds still elaborate.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick of the first pending path after last_grant.
module rr_select
  import key_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PATHS = 4,
  parameter int unsigned GW        = idx_width(NUM_PATHS)
) (
  input  logic [NUM_PATHS-1:0] pending,
  input  logic [GW-1:0]        last_grant,
  output logic [GW-1:0]        grant,
  output logic                 any
);

  logic [GW-1:0] cand;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_PATHS; k++) begin
      cand = GW'((32'(last_grant) + k) % NUM_PATHS);
      if (!any && pending[cand]) begin
        any   = 1'b1;
        grant = cand;
      end
    end
  end

endmodule

// File: rtl/key_arbiter.sv
// Arbitrates per-path key requests onto a single keymem request channel with timeout.
module key_arbiter
  import key_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PATHS      = 4,
  parameter int unsigned KEY_ID_WIDTH   = 32,
  parameter int unsigned KEY_WIDTH      = 256,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                             clk156,
  input  logic                             areset_clk156,
  input  logic [NUM_PATHS-1:0]             path_key_req,
  input  logic [NUM_PATHS*KEY_ID_WIDTH-1:0] path_key_id,
  output logic [NUM_PATHS-1:0]             path_key_ack,
  output logic [NUM_PATHS-1:0]             path_key_err,
  output logic [KEY_WIDTH-1:0]             path_key,
  output logic                             km_key_req,
  output logic [KEY_ID_WIDTH-1:0]          km_key_id,
  input  logic                             km_key_ack,
  input  logic [KEY_WIDTH-1:0]             km_key,
  output logic [15:0]                      drop_count
);

  localparam int unsigned GW         = idx_width(NUM_PATHS);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                  state, state_next;
  logic [NUM_PATHS-1:0]    pending, clear_mask, set_mask, drop_mask;
  logic [KEY_ID_WIDTH-1:0] id_q [NUM_PATHS];
  logic [GW-1:0]           grant, last_grant, sel;
  logic                    sel_any;
  logic [15:0]             timer;
  logic                    start, done_ack, done_err;
  logic [16:0]             drop_sum;
  logic [15:0]             drop_next;

  rr_select #(
    .NUM_PATHS (NUM_PATHS),
    .GW        (GW)
  ) u_rr_select (
    .pending    (pending),
    .last_grant (last_grant),
    .grant      (sel),
    .any        (sel_any)
  );

  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) state <= ST_IDLE;
    else               state <= state_next;
  end

  // Ack is tested before the timer so a coincident ack suppresses the error.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    done_ack   = 1'b0;
    done_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_any) begin
          start      = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (km_key_ack) begin
          done_ack   = 1'b1;
          state_next = ST_IDLE;
        end else if (timer == TIMER_LAST) begin
          done_err   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A request landing on the path being retired re-arms it rather than dropping.
  always_comb begin
    clear_mask = '0;
    if (done_ack || done_err) clear_mask[grant] = 1'b1;
    set_mask  = path_key_req & (~pending | clear_mask);
    drop_mask = path_key_req & pending & ~clear_mask;
    drop_sum  = {1'b0, drop_count};
    for (int unsigned i = 0; i < NUM_PATHS; i++) begin
      drop_sum = drop_sum + 17'(drop_mask[i]);
    end
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      pending      <= '0;
      for (int unsigned i = 0; i < NUM_PATHS; i++) id_q[i] <= '0;
      last_grant   <= GW'(NUM_PATHS - 1);
      grant        <= '0;
      timer        <= '0;
      path_key_ack <= '0;
      path_key_err <= '0;
      path_key     <= '0;
      km_key_req   <= 1'b0;
      km_key_id    <= '0;
      drop_count   <= '0;
    end else begin
      pending <= (pending & ~clear_mask) | set_mask;
      for (int unsigned i = 0; i < NUM_PATHS; i++) begin
        if (set_mask[i]) id_q[i] <= path_key_id[i*KEY_ID_WIDTH +: KEY_ID_WIDTH];
      end
      km_key_req   <= start;
      path_key_ack <= '0;
      path_key_err <= '0;
      if (start) begin
        grant     <= sel;
        km_key_id <= id_q[sel];
        timer     <= '0;
      end else if (state == ST_WAIT) begin
        timer <= timer + 16'd1;
      end
      if (done_ack) begin
        path_key_ack[grant] <= 1'b1;
        path_key            <= km_key;
      end
      if (done_err) path_key_err[grant] <= 1'b1;
      if (done_ack || done_err) last_grant <= grant;
      drop_count <= drop_next;
    end
  end

endmodule

// File: tb/tb_key_arbiter.sv
// Self-checking bench for key_arbiter: directed scenarios, vector table, random traffic vs reference model.
module tb_key_arbiter;

  localparam int NP = 4;
  localparam int TO = 8;

  logic            clk    = 1'b0;
  logic            rst    = 1'b0;
  logic [NP-1:0]   req    = '0;
  logic [NP*32-1:0] req_id = '0;
  logic [NP-1:0]   ack_o, err_o;
  logic [255:0]    pkey;
  logic            kreq;
  logic [31:0]     kid;
  logic            kack   = 1'b0;
  logic [255:0]    kkey   = '0;
  logic [15:0]     dc;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  key_arbiter #(
    .NUM_PATHS      (NP),
    .KEY_ID_WIDTH   (32),
    .KEY_WIDTH      (256),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk156        (clk),
    .areset_clk156 (rst),
    .path_key_req  (req),
    .path_key_id   (req_id),
    .path_key_ack  (ack_o),
    .path_key_err  (err_o),
    .path_key      (pkey),
    .km_key_req    (kreq),
    .km_key_id     (kid),
    .km_key_ack    (kack),
    .km_key        (kkey),
    .drop_count    (dc)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pending set, FIFO-free round-robin search, one outstanding keymem job.
  logic [NP-1:0] m_pend;
  logic [31:0]   m_id [NP];
  int            m_last, m_g, m_age;
  bit            m_busy;
  logic [NP-1:0] e_ack, e_err;
  logic [255:0]  e_key;
  logic          e_kreq;
  logic [31:0]   e_kid;
  logic [15:0]   e_dc;

  task automatic model_reset();
    m_pend = '0;
    for (int i = 0; i < NP; i++) m_id[i] = '0;
    m_last = NP - 1;
    m_g = 0; m_age = 0; m_busy = 1'b0;
    e_ack = '0; e_err = '0; e_key = '0; e_kreq = 1'b0; e_kid = '0; e_dc = '0;
  endtask

  task automatic model_step();
    logic [NP-1:0] pold;
    bit done;
    int p;
    pold = m_pend;
    done = 1'b0;
    e_ack = '0; e_err = '0; e_kreq = 1'b0;
    if (m_busy) begin
      if (kack) begin
        e_ack[m_g] = 1'b1; e_key = kkey; done = 1'b1;
      end else if (m_age == TO - 1) begin
        e_err[m_g] = 1'b1; done = 1'b1;
      end else begin
        m_age++;
      end
      if (done) begin
        m_busy = 1'b0; m_last = m_g; m_pend[m_g] = 1'b0;
      end
    end else begin
      for (int k = 1; k <= NP; k++) begin
        p = (m_last + k) % NP;
        if (!m_busy && pold[p]) begin
          m_busy = 1'b1; m_g = p; m_age = 0; e_kreq = 1'b1; e_kid = m_id[p];
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (req[i]) begin
        if (!pold[i] || (done && i == m_g)) begin
          m_pend[i] = 1'b1;
          m_id[i]   = req_id[i*32 +: 32];
        end else if (e_dc != 16'hFFFF) begin
          e_dc = e_dc + 16'd1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else     model_step();
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("mon_ack",  256'(ack_o), 256'(e_ack));
      chk("mon_err",  256'(err_o), 256'(e_err));
      chk("mon_key",  pkey,        e_key);
      chk("mon_kreq", 256'(kreq),  256'(e_kreq));
      chk("mon_kid",  256'(kid),   256'(e_kid));
      chk("mon_drop", 256'(dc),    256'(e_dc));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; kack = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic wait_kreq(input int limit);
    int n = 0;
    while (kreq !== 1'b1 && n < limit) begin
      cyc();
      n++;
    end
    chk("kreq_seen", 256'(kreq), 256'(1'b1));
  endtask

  typedef struct {
    logic [3:0]  mask;
    int          delay;
    int          n;
    logic [15:0] order;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [NP-1:0] seen;
    logic [15:0]   ord;
    logic [3:0]    onehot;
    logic [255:0]  k;
    int            p;

    vt[0] = '{mask: 4'b1111, delay: 1, n: 4, order: 16'h3210};
    vt[1] = '{mask: 4'b0100, delay: 0, n: 1, order: 16'h0002};
    vt[2] = '{mask: 4'b1010, delay: 3, n: 2, order: 16'h0031};
    vt[3] = '{mask: 4'b1001, delay: 2, n: 2, order: 16'h0030};
    vt[4] = '{mask: 4'b1000, delay: 0, n: 1, order: 16'h0003};
    vt[5] = '{mask: 4'b0110, delay: 5, n: 2, order: 16'h0021};

    #1;
    do_reset();
    mon_en = 1'b1;
    chk("rst_ack",  256'(ack_o), 256'(0));
    chk("rst_err",  256'(err_o), 256'(0));
    chk("rst_key",  pkey,        256'(0));
    chk("rst_kreq", 256'(kreq),  256'(0));
    chk("rst_kid",  256'(kid),   256'(0));
    chk("rst_drop", 256'(dc),    256'(0));

    // Basic latency: path 2, ack five cycles after the keymem request.
    req[2] = 1'b1; req_id[64 +: 32] = 32'h0000_0042;
    cyc(); req = '0;
    chk("lat_t1_kreq", 256'(kreq), 256'(0));
    cyc();
    chk("lat_t2_kreq", 256'(kreq), 256'(1));
    chk("lat_kid",     256'(kid),  256'(32'h42));
    repeat (5) cyc();
    chk("lat_pre_ack", 256'(ack_o), 256'(0));
    kack = 1'b1; kkey = {32{8'hAA}};
    cyc(); kack = 1'b0; kkey = '0;
    chk("lat_ack", 256'(ack_o), 256'(4'b0100));
    chk("lat_key", pkey, {32{8'hAA}});
    cyc();
    chk("lat_ack_off",  256'(ack_o), 256'(0));
    chk("lat_key_hold", pkey, {32{8'hAA}});

    // Vector table: simultaneous request masks serviced in round-robin order after reset.
    foreach (vt[v]) begin
      do_reset();
      for (int i = 0; i < NP; i++) req_id[i*32 +: 32] = 32'h100 * (v + 1) + i;
      req = vt[v].mask;
      cyc(); req = '0;
      ord = vt[v].order;
      for (int s = 0; s < vt[v].n; s++) begin
        p = int'(ord[s*4 +: 4]);
        wait_kreq(20);
        chk("vec_kid", 256'(kid), 256'(32'h100 * (v + 1) + p));
        repeat (vt[v].delay) cyc();
        k = {8{32'hC0DE_0000 | 32'(p)}};
        kack = 1'b1; kkey = k;
        cyc(); kack = 1'b0;
        onehot = 4'b0001 << p;
        chk("vec_ack", 256'(ack_o), 256'(onehot));
        chk("vec_key", pkey, k);
        chk("vec_err", 256'(err_o), 256'(0));
      end
    end

    // Timeout: no ack, error exactly TO cycles after the request, late ack ignored.
    do_reset();
    req[1] = 1'b1; req_id[32 +: 32] = 32'h11;
    cyc(); req = '0;
    wait_kreq(5);
    seen = '0;
    for (int c = 1; c <= TO; c++) begin
      cyc();
      if (c < TO) seen |= err_o | ack_o;
    end
    chk("to_early", 256'(seen),  256'(0));
    chk("to_err",   256'(err_o), 256'(4'b0010));
    chk("to_ack",   256'(ack_o), 256'(0));
    kack = 1'b1; kkey = '1;
    cyc(); kack = 1'b0; kkey = '0;
    chk("late_ack", 256'(ack_o), 256'(0));
    chk("late_err", 256'(err_o), 256'(0));
    chk("late_key", pkey, 256'(0));
    cyc();
    chk("late_kreq", 256'(kreq), 256'(0));

    // Repeated pulses on a pending path are dropped and counted.
    do_reset();
    req[1] = 1'b1; req_id[32 +: 32] = 32'h101;
    cyc(); req_id[32 +: 32] = 32'h202;
    cyc(); req_id[32 +: 32] = 32'h303;
    chk("drop_kreq", 256'(kreq), 256'(1));
    chk("drop_kid",  256'(kid),  256'(32'h101));
    cyc(); req = '0;
    chk("drop_cnt", 256'(dc), 256'(2));
    kack = 1'b1; kkey = {8{32'h1234_5678}};
    cyc(); kack = 1'b0;
    chk("drop_ack", 256'(ack_o), 256'(4'b0010));
    seen = '0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      seen |= ack_o | {3'b0, kreq};
    end
    chk("drop_single", 256'(seen), 256'(0));
    chk("drop_cnt2",   256'(dc),   256'(2));

    // Request on the granted path in its completion cycle re-arms it.
    do_reset();
    req[3] = 1'b1; req_id[96 +: 32] = 32'h33;
    cyc(); req = '0;
    wait_kreq(5);
    chk("rearm_kid0", 256'(kid), 256'(32'h33));
    repeat (2) cyc();
    kack = 1'b1; kkey = {8{32'hFEED_0003}};
    req[3] = 1'b1; req_id[96 +: 32] = 32'h34;
    cyc(); kack = 1'b0; req = '0;
    chk("rearm_ack",  256'(ack_o), 256'(4'b1000));
    chk("rearm_drop", 256'(dc),    256'(0));
    cyc();
    chk("rearm_kreq", 256'(kreq), 256'(1));
    chk("rearm_kid",  256'(kid),  256'(32'h34));

    // Reset two cycles into WAIT abandons the transaction.
    do_reset();
    req[0] = 1'b1; req_id[0 +: 32] = 32'h5;
    cyc(); req = '0;
    wait_kreq(5);
    repeat (2) cyc();
    rst = 1'b1;
    #1;
    chk("arst_kid", 256'(kid), 256'(0));
    cyc(); rst = 1'b0;
    kack = 1'b1; kkey = '1;
    cyc(); kack = 1'b0; kkey = '0;
    seen = '0;
    for (int c = 0; c < 12; c++) begin
      seen |= ack_o | err_o;
      cyc();
    end
    chk("arst_pulses", 256'(seen), 256'(0));
    chk("arst_kreq",   256'(kreq), 256'(0));
    chk("arst_kid2",   256'(kid),  256'(0));
    chk("arst_key",    pkey,       256'(0));
    chk("arst_drop",   256'(dc),   256'(0));

    // Random traffic, random acks (including late ones and timeouts), one mid-run reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        req[i] = ($urandom_range(0, 4) == 0);
        req_id[i*32 +: 32] = $urandom;
      end
      kack = ($urandom_range(0, 5) == 0);
      for (int j = 0; j < 8; j++) kkey[j*32 +: 32] = $urandom;
      rst = (c == 1500);
      cyc();
    end
    rst = 1'b0; req = '0; kack = 1'b0;
    cyc();

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < NP; i++) req_id[i*32 +: 32] = 32'hD000 + i;
    req = '1;
    repeat (18000) cyc();
    chk("sat_drop", 256'(dc), 256'(16'hFFFF));
    repeat (20) cyc();
    chk("sat_hold", 256'(dc), 256'(16'hFFFF));
    req = '0;
    cyc();

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
